enigma_step_ctrl: RTL and testbench
===================================

Name: enigma_step_ctrl

Overview:
- Frame-level sequencer and rotor stepping controller for the enigma encryption datapath.
- Holds the key (initial rotor positions) and frames a message of `symb_numb_i` symbols.
- Steps three rotors per valid symbol, with odometer carry and historical double-step.
- Presents registered rotor positions to the substitution datapath and flags frame completion.

Parameters:
- ALPHA, 26, alphabet size; positions wrap modulo ALPHA.
- POS_W, 5, rotor position width; requires ALPHA <= 2**POS_W.
- NOTCH0, 16, fast-rotor position that causes the middle rotor to step.
- NOTCH1, 4, middle-rotor position that causes the slow rotor to step, and the middle rotor itself to double-step.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- key_val_i  in  1  load `key_pos0_i`..`key_pos2_i` into the key registers.
- key_pos0_i  in  POS_W  key position, fast rotor.
- key_pos1_i  in  POS_W  key position, middle rotor.
- key_pos2_i  in  POS_W  key position, slow rotor.
- frame_start_i  in  1  start a frame: reload rotors from the key, clear the count.
- symb_numb_i  in  8  frame length in symbols; sampled on `frame_start_i`.
- symb_val_i  in  1  one symbol presented this cycle.
- rot_pos0_o  out  POS_W  current fast-rotor position.
- rot_pos1_o  out  POS_W  current middle-rotor position.
- rot_pos2_o  out  POS_W  current slow-rotor position.
- pos_val_o  out  1  positions were updated for the symbol accepted last cycle.
- busy_o  out  1  frame in progress.
- frame_done_o  out  1  one-cycle pulse when the last symbol is stepped.
- proto_err_o  out  1  sticky: `symb_val_i` arrived outside a frame.

Behaviour:
- Reset values:
  - all outputs 0, key registers 0, count 0, state IDLE.
- Key registers:
  - Load on `key_val_i` in any state.
  - Out-of-range values (>= ALPHA) are reduced by subtracting ALPHA once.
  - A new key takes effect only at the next `frame_start_i`.
- States: IDLE, RUN, DONE.
- IDLE:
  - `frame_start_i` -> rotors <= key, count <= 0, `len` <= `symb_numb_i`, `proto_err_o` <= 0.
  - Next state is RUN if `len` != 0, otherwise DONE.
  - `symb_val_i` without `frame_start_i` -> ignored, `proto_err_o` <= 1.
- RUN:
  - Each `symb_val_i` steps the rotors (step-before-encipher), count++.
  - `rot_pos*_o` and `pos_val_o` update the next cycle; latency 1.
  - When count reaches `len`: `frame_done_o` pulses in the same cycle as the final `pos_val_o`, and the state goes to IDLE.
- DONE (zero-length frame only): `frame_done_o` pulse for one cycle -> IDLE; no stepping.
- Stepping rule, evaluated on pre-step positions p0/p1/p2:
  - s0 = 1.
  - s1 = (p0 == NOTCH0) | (p1 == NOTCH1).
  - s2 = (p1 == NOTCH1).
  - Each stepped rotor: p = (p == ALPHA-1) ? 0 : p + 1.
- `busy_o` = 1 in RUN and DONE.
- Simultaneous events:
  - `frame_start_i` in RUN aborts the current frame and restarts from the key; no `frame_done_o` for the aborted frame.
  - `frame_start_i` with `symb_val_i` in the same cycle: the symbol is not counted, not stepped, and not flagged.
- Reset mid-frame: immediate return to reset values, including the key.

Optional Feature:
- Macro: ENIGMA_DOUBLE_STEP_EN.
- Defined: the stepping rule is exactly as above (historical double-step anomaly).
- Undefined:
  - Pure odometer: s1 = (p0 == NOTCH0), s2 = s1 & (p1 == NOTCH1).
  - The middle rotor never steps on its own notch.

Decomposition:
- Package enigma_pkg holds:
  - ALPHA, POS_W, default notch constants.
  - typedef `rot_pos_t` (logic [POS_W-1:0]).
  - enum `step_state_t` {IDLE, RUN, DONE}.
  - typedef `rot_set_t` (struct of three `rot_pos_t`).
- Sub-module enigma_rotor_inc: combinational modulo-ALPHA increment with enable; instantiated three times.

Test Plan:
- Key (0,0,0), `symb_numb_i`=3, three `symb_val_i` -> `pos_val_o` with (1,0,0), (2,0,0), (3,0,0); `frame_done_o` with the third; `busy_o` falls the next cycle.
- Key (16,3,0), 2 symbols, ENIGMA_DOUBLE_STEP_EN defined -> (17,4,0), then (18,5,1).
- Same stimulus with the macro undefined -> (17,4,0), then (18,4,0).
- Key (25,25,25), 1 symbol -> (0,25,25) (wrap, no carry); `frame_done_o`=1.
- `symb_numb_i`=0 -> `frame_done_o` pulses 2 cycles after `frame_start_i`, no `pos_val_o`. Separately, `symb_val_i` in IDLE -> `proto_err_o`=1, cleared by the next `frame_start_i`.
- Frame of 5, `frame_start_i` after the 2nd symbol with new key (7,0,0) -> positions restart at (8,0,0); only one `frame_done_o`, after 5 more symbols. Assert `rst_i` mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared constants and types for the enigma rotor stepping logic.
//   ALPHA       alphabet size; rotor positions wrap modulo ALPHA
//   POS_W       rotor position width (ALPHA <= 2**POS_W)
//   NOTCH*_DEF  default notch positions for the fast and middle rotors
package enigma_pkg;

  localparam int unsigned ALPHA      = 26;
  localparam int unsigned POS_W      = 5;
  localparam int unsigned NOTCH0_DEF = 16;
  localparam int unsigned NOTCH1_DEF = 4;
  localparam int unsigned CNT_W      = 8;

  typedef logic [POS_W-1:0] rot_pos_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } step_state_t;

  typedef struct packed {
    rot_pos_t p2;
    rot_pos_t p1;
    rot_pos_t p0;
  } rot_set_t;

  // Fold an out-of-range key position back into the alphabet (single subtract).
  function automatic rot_pos_t key_reduce(input rot_pos_t k);
    return (k >= rot_pos_t'(ALPHA)) ? rot_pos_t'(k - rot_pos_t'(ALPHA)) : k;
  endfunction

endpackage

// File: rtl/enigma_rotor_inc.sv
// enigma_rotor_inc: combinational modulo-ALPHA increment with enable.
//   pos         current rotor position
//   en          step this rotor
//   pos_next_c  position after the (optional) step
module enigma_rotor_inc
  import enigma_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  logic             en,
  output logic [POS_W-1:0] pos_next_c
);

  always_comb begin
    pos_next_c = pos;
    if (en) begin
      pos_next_c = (pos == rot_pos_t'(ALPHA - 1)) ? '0 : rot_pos_t'(pos + rot_pos_t'(1));
    end
  end

endmodule

// File: rtl/enigma_step_ctrl.sv
// enigma_step_ctrl: frame sequencer and three-rotor stepping controller.
// Holds the key, frames a message of symb_numb_i symbols and steps the rotors
// (odometer carry) once per accepted symbol, before encipherment.
// Optional macro ENIGMA_DOUBLE_STEP_EN enables the historical double-step
// anomaly of the middle rotor; otherwise the rotors behave as a pure odometer.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   key_val_i, key_pos*_i   key load strobe and fast/middle/slow key positions
//   frame_start_i           start (or restart) a frame from the key
//   symb_numb_i             frame length, sampled on frame_start_i
//   symb_val_i              one symbol presented this cycle
//   rot_pos*_o              registered fast/middle/slow rotor positions
//   pos_val_o               positions updated for the symbol accepted last cycle
//   busy_o                  frame in progress
//   frame_done_o            pulse with the final pos_val_o (or for an empty frame)
//   proto_err_o             sticky: symbol seen outside a frame
module enigma_step_ctrl
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH0 = NOTCH0_DEF,
  parameter int unsigned NOTCH1 = NOTCH1_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             key_val_i,
  input  logic [POS_W-1:0] key_pos0_i,
  input  logic [POS_W-1:0] key_pos1_i,
  input  logic [POS_W-1:0] key_pos2_i,
  input  logic             frame_start_i,
  input  logic [CNT_W-1:0] symb_numb_i,
  input  logic             symb_val_i,
  output logic [POS_W-1:0] rot_pos0_o,
  output logic [POS_W-1:0] rot_pos1_o,
  output logic [POS_W-1:0] rot_pos2_o,
  output logic             pos_val_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             proto_err_o
);

  localparam rot_pos_t NOTCH0_POS = rot_pos_t'(NOTCH0);
  localparam rot_pos_t NOTCH1_POS = rot_pos_t'(NOTCH1);

  step_state_t      state_q;
  rot_set_t         key_q;
  rot_set_t         rot_q;
  rot_set_t         rot_step_c;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] count_inc_c;
  logic             s1_c;
  logic             s2_c;

  // Step enables from the pre-step positions; the fast rotor always steps.
`ifdef ENIGMA_DOUBLE_STEP_EN
  assign s1_c = (rot_q.p0 == NOTCH0_POS) | (rot_q.p1 == NOTCH1_POS);
  assign s2_c = (rot_q.p1 == NOTCH1_POS);
`else
  assign s1_c = (rot_q.p0 == NOTCH0_POS);
  assign s2_c = s1_c & (rot_q.p1 == NOTCH1_POS);
`endif

  enigma_rotor_inc u_inc0 (.pos(rot_q.p0), .en(1'b1), .pos_next_c(rot_step_c.p0));
  enigma_rotor_inc u_inc1 (.pos(rot_q.p1), .en(s1_c), .pos_next_c(rot_step_c.p1));
  enigma_rotor_inc u_inc2 (.pos(rot_q.p2), .en(s2_c), .pos_next_c(rot_step_c.p2));

  assign count_inc_c = CNT_W'(count_q + CNT_W'(1));

  // Key registers: loadable any time, applied to the rotors only at frame start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_q <= '0;
    end else if (key_val_i) begin
      key_q.p0 <= key_reduce(key_pos0_i);
      key_q.p1 <= key_reduce(key_pos1_i);
      key_q.p2 <= key_reduce(key_pos2_i);
    end
  end

  // Frame FSM; frame_start_i takes priority over everything and swallows a
  // coincident symbol.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rot_q        <= '0;
      count_q      <= '0;
      len_q        <= '0;
      pos_val_o    <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      proto_err_o  <= 1'b0;
    end else begin
      pos_val_o    <= 1'b0;
      frame_done_o <= 1'b0;
      if (frame_start_i) begin
        rot_q       <= key_q;
        count_q     <= '0;
        len_q       <= symb_numb_i;
        proto_err_o <= 1'b0;
        busy_o      <= 1'b1;
        state_q     <= (symb_numb_i != '0) ? RUN : DONE;
      end else begin
        case (state_q)
          IDLE: begin
            if (symb_val_i) begin
              proto_err_o <= 1'b1;
            end
          end
          RUN: begin
            if (symb_val_i) begin
              rot_q     <= rot_step_c;
              pos_val_o <= 1'b1;
              count_q   <= count_inc_c;
              if (count_inc_c == len_q) begin
                frame_done_o <= 1'b1;
                busy_o       <= 1'b0;
                state_q      <= IDLE;
              end
            end
          end
          DONE: begin
            frame_done_o <= 1'b1;
            busy_o       <= 1'b0;
            state_q      <= IDLE;
          end
          default: begin
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign rot_pos0_o = rot_q.p0;
  assign rot_pos1_o = rot_q.p1;
  assign rot_pos2_o = rot_q.p2;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// tb_enigma_step_ctrl: directed self-checking bench for enigma_step_ctrl.
// Expected values are hand-computed; the double-step vector follows
// ENIGMA_DOUBLE_STEP_EN as the DUT does.
module tb_enigma_step_ctrl;

  logic       clk;
  logic       rst;
  logic       key_val;
  logic [4:0] key0, key1, key2;
  logic       frame_start;
  logic [7:0] symb_numb;
  logic       symb_val;
  logic [4:0] rot0, rot1, rot2;
  logic       pos_val, busy, frame_done, proto_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt = 0;
  int unsigned done_base;

  enigma_step_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .key_val_i    (key_val),
    .key_pos0_i   (key0),
    .key_pos1_i   (key1),
    .key_pos2_i   (key2),
    .frame_start_i(frame_start),
    .symb_numb_i  (symb_numb),
    .symb_val_i   (symb_val),
    .rot_pos0_o   (rot0),
    .rot_pos1_o   (rot1),
    .rot_pos2_o   (rot2),
    .pos_val_o    (pos_val),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .proto_err_o  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_rot(input string tag, input int unsigned e0, input int unsigned e1,
                           input int unsigned e2);
    check({tag, ".p0"}, rot0, e0);
    check({tag, ".p1"}, rot1, e1);
    check({tag, ".p2"}, rot2, e2);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int unsigned k0, input int unsigned k1, input int unsigned k2);
    key_val = 1'b1;
    key0 = 5'(k0);
    key1 = 5'(k1);
    key2 = 5'(k2);
    step();
    key_val = 1'b0;
  endtask

  task automatic start_frame(input int unsigned len);
    frame_start = 1'b1;
    symb_numb = 8'(len);
    step();
    frame_start = 1'b0;
  endtask

  task automatic send_sym();
    symb_val = 1'b1;
    step();
    symb_val = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    key_val = 1'b0;
    key0 = '0; key1 = '0; key2 = '0;
    frame_start = 1'b0;
    symb_numb = '0;
    symb_val = 1'b0;
    step();
    step();
    check_rot("reset_rot", 0, 0, 0);
    check("reset_pos_val", pos_val, 0);
    check("reset_busy", busy, 0);
    check("reset_done", frame_done, 0);
    check("reset_perr", proto_err, 0);
    rst = 1'b0;
    step();

    // Plain three-symbol frame from key (0,0,0)
    load_key(0, 0, 0);
    start_frame(3);
    check("f1_busy", busy, 1);
    check("f1_pos_val0", pos_val, 0);
    check_rot("f1_start", 0, 0, 0);
    symb_val = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("f1_pos_val", pos_val, 1);
      check_rot("f1_step", i, 0, 0);
      check("f1_done", frame_done, (i == 3) ? 1 : 0);
      check("f1_busy_run", busy, (i == 3) ? 0 : 1);
    end
    symb_val = 1'b0;
    step();
    check("f1_done_clr", frame_done, 0);
    check("f1_pos_val_clr", pos_val, 0);

    // Notch carry and double-step
    load_key(16, 3, 0);
    start_frame(2);
    send_sym();
    check_rot("ds_1", 17, 4, 0);
    check("ds_1_done", frame_done, 0);
    send_sym();
`ifdef ENIGMA_DOUBLE_STEP_EN
    check_rot("ds_2", 18, 5, 1);
`else
    check_rot("ds_2", 18, 4, 0);
`endif
    check("ds_2_done", frame_done, 1);
    step();

    // Wrap with no carry
    load_key(25, 25, 25);
    start_frame(1);
    send_sym();
    check_rot("wrap", 0, 25, 25);
    check("wrap_done", frame_done, 1);
    check("wrap_pos_val", pos_val, 1);
    step();

    // Out-of-range key reduction and zero-length frame
    load_key(30, 31, 26);
    start_frame(0);
    check_rot("kred", 4, 5, 0);
    check("z_busy", busy, 1);
    check("z_done_early", frame_done, 0);
    step();
    check("z_done", frame_done, 1);
    check("z_pos_val", pos_val, 0);
    check("z_busy_end", busy, 0);
    step();
    check("z_done_clr", frame_done, 0);

    // Protocol error in IDLE, cleared by frame start with a coincident symbol
    send_sym();
    check("perr_set", proto_err, 1);
    check("perr_pos_val", pos_val, 0);
    check_rot("perr_rot", 4, 5, 0);
    step();
    check("perr_sticky", proto_err, 1);
    frame_start = 1'b1;
    symb_numb = 8'd2;
    symb_val = 1'b1;
    step();
    frame_start = 1'b0;
    symb_val = 1'b0;
    check("perr_clr", proto_err, 0);
    check("coinc_pos_val", pos_val, 0);
    check_rot("coinc_rot", 4, 5, 0);

    // Abort a running frame with a new key
    done_base = done_cnt;
    load_key(0, 0, 0);
    start_frame(5);
    send_sym();
    send_sym();
    check_rot("ab_pre", 2, 0, 0);
    load_key(7, 0, 0);
    check_rot("ab_key_wait", 2, 0, 0);
    check("ab_busy", busy, 1);
    start_frame(5);
    check_rot("ab_restart", 7, 0, 0);
    check("ab_restart_pv", pos_val, 0);
    for (int i = 0; i < 5; i++) begin
      send_sym();
      check_rot("ab_step", 8 + i, 0, 0);
      check("ab_done", frame_done, (i == 4) ? 1 : 0);
    end
    step();
    check("ab_done_cnt", done_cnt - done_base, 1);

    // Asynchronous reset mid-frame, including the key
    load_key(3, 3, 3);
    start_frame(4);
    send_sym();
    check_rot("rst_pre", 4, 3, 3);
    rst = 1'b1;
    #1;
    check_rot("rst_mid", 0, 0, 0);
    check("rst_busy", busy, 0);
    check("rst_pos_val", pos_val, 0);
    step();
    rst = 1'b0;
    start_frame(1);
    check_rot("rst_key", 0, 0, 0);
    send_sym();
    check_rot("rst_after", 1, 0, 0);
    check("rst_after_done", frame_done, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
